// File: rtl/spike_train_tx.sv
// rtl/spike_train_tx.sv - periodic spike generator with window-synchronous reconfiguration and counting
//
// Emits a pulse train on spike_out with a programmable period and high time.
// New settings are staged through a shadow register (load) and take effect on
// the next synchronized sim_clk rising edge (window_tick), which also latches
// the number of spikes emitted during the window just completed.
//
// Ports:
//   clk          in   fast clock; all state on its rising edge
//   reset_global in   asynchronous active-high reset
//   sim_clk      in   window clock, asynchronous to clk
//   enable       in   1 = emit spikes, 0 = finish current pulse then idle
//   load         in   strobe capturing period/pulse_width into the shadow
//   period       in   [31:0] clk cycles between rising edges, 0 = silence
//   pulse_width  in   [7:0]  spike high time in clk cycles
//   spike_out    out  registered spike line
//   spike_cnt    out  [31:0] rising edges in the last completed window
//   window_tick  out  one-cycle pulse per synchronized sim_clk rising edge
//   pending      out  shadow holds settings not yet applied

module spike_train_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PERIOD  = 2
) (
  input  logic        clk,
  input  logic        reset_global,
  input  logic        sim_clk,
  input  logic        enable,
  input  logic        load,
  input  logic [31:0] period,
  input  logic [7:0]  pulse_width,
  output logic        spike_out,
  output logic [31:0] spike_cnt,
  output logic        window_tick,
  output logic        pending
);

  localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // Synchronizer and edge detect
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   window_tick_q, window_tick_d;

  // Configuration
  logic [31:0] shadow_period_q, shadow_period_d;
  logic [7:0]  shadow_width_q, shadow_width_d;
  logic [31:0] active_period_q, active_period_d;
  logic [7:0]  active_width_q, active_width_d;
  logic        pending_q, pending_d;

  // Pulse generator
  state_t      state_q, state_d;
  logic [31:0] phase_q, phase_d;
  logic        spike_q, spike_d;

  // Counting
  logic [31:0] run_cnt_q, run_cnt_d;
  logic [31:0] spike_cnt_q, spike_cnt_d;

  // Helpers
  logic        sync_s;
  logic        apply;
  logic [31:0] eff_period;
  logic [31:0] eff_width;
  logic [31:0] new_eff_period;
  logic        stop;
  logic        start_on_apply;
  logic        rise;
  logic [31:0] run_inc;

  function automatic logic [31:0] f_eff_period(input logic [31:0] p);
    if (p == 32'd0)
      return 32'd0;
    else if (p < MIN_P)
      return MIN_P;
    else
      return p;
  endfunction

  // With ep = 0 the subtraction wraps to all ones, so the raw width is kept;
  // that only matters while a pulse drains after the period went to zero.
  function automatic logic [31:0] f_eff_width(input logic [7:0] w, input logic [31:0] ep);
    logic [31:0] w32;
    w32 = {24'd0, w};
    if (w == 8'd0)
      return 32'd1;
    else if (w32 > ep - 32'd1)
      return ep - 32'd1;
    else
      return w32;
  endfunction

  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], sim_clk};
    sync_s        = sync_q[SYNC_STAGES-1];
    hist_d        = sync_s;
    window_tick_d = sync_s & ~hist_q;
  end

  always_comb begin
    apply          = window_tick_q & pending_q;
    eff_period     = f_eff_period(active_period_q);
    eff_width      = f_eff_width(active_width_q, eff_period);
    new_eff_period = f_eff_period(shadow_period_q);
    // Stop also looks at settings being applied this cycle so that a pulse
    // train switched to silence never starts another pulse.
    stop           = ~enable | (eff_period == 32'd0) | (apply & (new_eff_period == 32'd0));
    start_on_apply = apply & enable & (new_eff_period != 32'd0);
  end

  // Shadow / active configuration. A load coinciding with the tick is staged
  // after the current shadow has been applied, so it stays pending.
  always_comb begin
    shadow_period_d = shadow_period_q;
    shadow_width_d  = shadow_width_q;
    active_period_d = active_period_q;
    active_width_d  = active_width_q;
    pending_d       = pending_q;
    if (apply) begin
      active_period_d = shadow_period_q;
      active_width_d  = shadow_width_q;
      pending_d       = 1'b0;
    end
    if (load) begin
      shadow_period_d = period;
      shadow_width_d  = pulse_width;
      pending_d       = 1'b1;
    end
  end

  // Pulse FSM: phase counts clk cycles from the rising edge and wraps at
  // eff_period - 1. Comparisons use >= so a reconfiguration that shrinks the
  // limits below the current phase still terminates the pulse.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        phase_d = 32'd0;
        if (!stop)
          state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (phase_q >= eff_width - 32'd1) begin
          if (stop) begin
            state_d = ST_IDLE;
            phase_d = 32'd0;
          end else begin
            state_d = ST_LOW;
            phase_d = phase_q + 32'd1;
          end
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      ST_LOW: begin
        if (stop) begin
          state_d = ST_IDLE;
          phase_d = 32'd0;
        end else if (phase_q >= eff_period - 32'd1) begin
          state_d = ST_HIGH;
          phase_d = 32'd0;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = 32'd0;
      end
    endcase
    if (start_on_apply) begin
      state_d = ST_HIGH;
      phase_d = 32'd0;
    end
  end

  // A rise produced on the tick cycle becomes visible in the new window, so
  // it seeds the fresh running count rather than the latched one.
  always_comb begin
    spike_d     = (state_d == ST_HIGH);
    rise        = spike_d & ~spike_q;
    run_inc     = (run_cnt_q == 32'hFFFF_FFFF) ? run_cnt_q : run_cnt_q + 32'd1;
    spike_cnt_d = spike_cnt_q;
    run_cnt_d   = run_cnt_q;
    if (window_tick_q) begin
      spike_cnt_d = run_cnt_q;
      run_cnt_d   = rise ? 32'd1 : 32'd0;
    end else if (rise) begin
      run_cnt_d   = run_inc;
    end
  end

  // Synchronizer resets high so a sim_clk already high at release is not
  // mistaken for a rising edge.
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      sync_q          <= '1;
      hist_q          <= 1'b1;
      window_tick_q   <= 1'b0;
      shadow_period_q <= 32'd0;
      shadow_width_q  <= 8'd1;
      active_period_q <= 32'd0;
      active_width_q  <= 8'd1;
      pending_q       <= 1'b0;
      state_q         <= ST_IDLE;
      phase_q         <= 32'd0;
      spike_q         <= 1'b0;
      run_cnt_q       <= 32'd0;
      spike_cnt_q     <= 32'd0;
    end else begin
      sync_q          <= sync_d;
      hist_q          <= hist_d;
      window_tick_q   <= window_tick_d;
      shadow_period_q <= shadow_period_d;
      shadow_width_q  <= shadow_width_d;
      active_period_q <= active_period_d;
      active_width_q  <= active_width_d;
      pending_q       <= pending_d;
      state_q         <= state_d;
      phase_q         <= phase_d;
      spike_q         <= spike_d;
      run_cnt_q       <= run_cnt_d;
      spike_cnt_q     <= spike_cnt_d;
    end
  end

  assign spike_out   = spike_q;
  assign spike_cnt   = spike_cnt_q;
  assign window_tick = window_tick_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_spike_train_tx.sv
// tb/tb_spike_train_tx.sv - self-checking bench for spike_train_tx

module tb_spike_train_tx;

  logic        clk = 1'b0;
  logic        reset_global;
  logic        sim_clk;
  logic        enable;
  logic        load;
  logic [31:0] period;
  logic [7:0]  pulse_width;
  logic        spike_out;
  logic [31:0] spike_cnt;
  logic        window_tick;
  logic        pending;

  spike_train_tx #(.SYNC_STAGES(2), .MIN_PERIOD(2)) dut (
    .clk         (clk),
    .reset_global(reset_global),
    .sim_clk     (sim_clk),
    .enable      (enable),
    .load        (load),
    .period      (period),
    .pulse_width (pulse_width),
    .spike_out   (spike_out),
    .spike_cnt   (spike_cnt),
    .window_tick (window_tick),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] per;
    logic [7:0]  wid;
    int          exp_hi;
    int          exp_lo;
  } vec_t;

  vec_t vecs[5];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] p, input logic [7:0] w);
    period      = p;
    pulse_width = w;
    load        = 1'b1;
    @(negedge clk);
    load        = 1'b0;
  endtask

  task automatic pulse_sim();
    sim_clk = 1'b0;
    repeat (4) @(negedge clk);
    sim_clk = 1'b1;
  endtask

  task automatic wait_tick(input int bound, output int lat);
    lat = bound;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (window_tick) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_rise(input int bound, output int ok);
    logic prev;
    prev = spike_out;
    ok   = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (spike_out && !prev) begin
        ok = 1;
        break;
      end
      prev = spike_out;
    end
  endtask

  // Starts on a negedge showing the first high cycle; ends on the first high
  // cycle of the following pulse.
  task automatic meas_pulse(output int hi, output int lo);
    hi = 1;
    lo = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (spike_out) hi++;
      else break;
    end
    lo = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!spike_out) lo++;
      else break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ok, hi, lo, cnt;

    vecs[0] = '{per: 32'd10, wid: 8'd2, exp_hi: 2, exp_lo: 8};
    vecs[1] = '{per: 32'd4,  wid: 8'd9, exp_hi: 3, exp_lo: 1};
    vecs[2] = '{per: 32'd4,  wid: 8'd0, exp_hi: 1, exp_lo: 3};
    vecs[3] = '{per: 32'd1,  wid: 8'd5, exp_hi: 1, exp_lo: 1};
    vecs[4] = '{per: 32'd3,  wid: 8'd1, exp_hi: 1, exp_lo: 2};

    reset_global = 1'b1;
    sim_clk      = 1'b1;
    enable       = 1'b0;
    load         = 1'b0;
    period       = 32'd0;
    pulse_width  = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_spike_out", spike_out, 0);
    check("rst_spike_cnt", spike_cnt, 0);
    check("rst_window_tick", window_tick, 0);
    check("rst_pending", pending, 0);
    reset_global = 1'b0;
    enable       = 1'b1;
    cnt = 0;
    hi  = 0;
    repeat (10) begin
      @(negedge clk);
      if (window_tick) cnt++;
      if (spike_out) hi++;
    end
    check("rst_no_tick_sim_high", cnt, 0);
    check("rst_idle_no_spike", hi, 0);

    // Table: period/width shaping, tick latency and first-rise timing.
    for (int i = 0; i < 5; i++) begin
      do_load(vecs[i].per, vecs[i].wid);
      check($sformatf("vec%0d_pending", i), pending, 1);
      pulse_sim();
      wait_tick(50, lat);
      check($sformatf("vec%0d_tick_latency", i), lat, 3);
      @(negedge clk);
      check($sformatf("vec%0d_first_rise", i), spike_out, 1);
      meas_pulse(hi, lo);
      check($sformatf("vec%0d_high", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_low", i), lo, vecs[i].exp_lo);
    end

    // 1000-cycle window at period 10, phase aligned to the tick.
    do_load(32'd10, 8'd2);
    sim_clk = 1'b0;
    repeat (4) @(negedge clk);
    sim_clk = 1'b1;
    repeat (500) @(negedge clk);
    sim_clk = 1'b0;
    repeat (500) @(negedge clk);
    sim_clk = 1'b1;
    wait_tick(50, lat);
    @(negedge clk);
    check("win1000_spike_cnt", spike_cnt, 100);

    // Mid-window reload: old period holds until the tick.
    do_load(32'd20, 8'd2);
    check("reload_pending", pending, 1);
    wait_rise(30, ok);
    meas_pulse(hi, lo);
    check("reload_old_period", hi + lo, 10);
    pulse_sim();
    wait_tick(50, lat);
    @(negedge clk);
    check("reload_pending_cleared", pending, 0);
    check("reload_first_rise", spike_out, 1);
    meas_pulse(hi, lo);
    check("reload_new_high", hi, 2);
    check("reload_new_low", lo, 18);

    // Load coinciding with tick: pre-load shadow (20,2) is what gets applied.
    do_load(32'd20, 8'd2);
    pulse_sim();
    wait_tick(50, lat);
    do_load(32'd6, 8'd1);
    check("coinc_still_pending", pending, 1);
    meas_pulse(hi, lo);
    check("coinc_old_shadow_period", hi + lo, 20);

    // Enable dropped on first high cycle of a width-5 pulse.
    do_load(32'd20, 8'd5);
    pulse_sim();
    wait_tick(50, lat);
    @(negedge clk);
    check("drain_first_rise", spike_out, 1);
    enable = 1'b0;
    hi = 1;
    repeat (60) begin
      @(negedge clk);
      if (spike_out) hi++;
    end
    check("drain_total_high", hi, 5);

    // Silence: period 0 applied; previous window held only the tick-aligned rise.
    do_load(32'd0, 8'd0);
    pulse_sim();
    wait_tick(50, lat);
    enable = 1'b1;
    @(negedge clk);
    check("silence_prev_window_cnt", spike_cnt, 1);
    pulse_sim();
    wait_tick(50, lat);
    @(negedge clk);
    check("silence_spike_cnt", spike_cnt, 0);
    check("silence_spike_out", spike_out, 0);

    // Reset mid-pulse with sim_clk held high.
    do_load(32'd10, 8'd5);
    pulse_sim();
    wait_tick(50, lat);
    repeat (30) @(negedge clk);
    pulse_sim();
    wait_tick(50, lat);
    wait_rise(30, ok);
    check("prereset_rise_seen", ok, 1);
    #2;
    reset_global = 1'b1;
    #1;
    check("reset_async_spike_out", spike_out, 0);
    check("reset_spike_cnt", spike_cnt, 0);
    check("reset_pending", pending, 0);
    @(negedge clk);
    @(negedge clk);
    reset_global = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (window_tick) cnt++;
    end
    check("postreset_no_tick", cnt, 0);
    pulse_sim();
    wait_tick(50, lat);
    check("postreset_tick_latency", lat, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_train_tx.md
SPIKE_TRAIN_TX -- requirements
Module: spike_train_tx

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2: number of flops in the sim_clk synchronizer (min 2).
REQ-002 SHALL provide parameter MIN_PERIOD, default 2: smallest spike period in clk cycles; nonzero requested periods below this are raised to it.
REQ-003 SHALL have port clk, input, 1: fast clock (clk1 domain); all logic is on its rising edge.
REQ-004 SHALL have port reset_global, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port sim_clk, input, 1: window clock from gen_clk, asynchronous to clk.
REQ-006 SHALL have port enable, input, 1: 1 = emit spikes; 0 = go idle.
REQ-007 SHALL have port load, input, 1: single-cycle strobe that captures period and pulse_width into shadow registers.
REQ-008 SHALL have port period, input, 32: unsigned clk cycles between spike rising edges; 0 = silence.
REQ-009 SHALL have port pulse_width, input, 8: unsigned spike high time in clk cycles.
REQ-010 SHALL have port spike_out, output, 1: registered cross-board spike line.
REQ-011 SHALL have port spike_cnt, output, 32: rising edges emitted in the last completed window.
REQ-012 SHALL have port window_tick, output, 1: one-cycle pulse per synchronized sim_clk rising edge.
REQ-013 SHALL have port pending, output, 1: shadow values are loaded but not yet applied.

Function
REQ-014 SHALL pass sim_clk through SYNC_STAGES flops plus a history flop, and assert window_tick for one cycle when the synchronized value goes 0->1 (latency SYNC_STAGES+1 cycles).
REQ-015 SHALL, on load=1, capture period and pulse_width into shadow registers and set pending=1; a load while pending is already 1 overwrites the shadow and pending stays 1.
REQ-016 SHALL, on window_tick with pending=1, copy shadow to active registers, clear pending, and restart the phase (state HIGH, phase counter 0).
REQ-017 SHALL, when load and window_tick coincide, apply the pre-load shadow contents; the new load remains pending for the next tick.
REQ-018 SHALL derive the effective period as: 0 if active period is 0; otherwise max(active period, MIN_PERIOD).
REQ-019 SHALL derive the effective width as: 1 if pulse_width is 0; otherwise min(pulse_width, effective period - 1).
REQ-020 SHALL implement the FSM IDLE/HIGH/LOW with a 32-bit phase counter that wraps from effective period - 1 to 0, and spike_out = 1 exactly when the registered state is HIGH.
REQ-021 SHALL go IDLE->HIGH (phase 0) on the first cycle where enable=1 and effective period != 0; spike_out rises one cycle later.
REQ-022 SHALL go HIGH->LOW when phase = effective width - 1.
REQ-023 SHALL go LOW->HIGH when the phase wraps to 0.
REQ-024 SHALL, when enable falls or effective period becomes 0 during HIGH, complete the current pulse (no runt pulse) and then go IDLE; during LOW it SHALL go IDLE immediately. IDLE holds phase 0.
REQ-025 SHALL count spike_out rising edges in a 32-bit running counter that saturates at 0xFFFFFFFF.
REQ-026 SHALL, on window_tick, load spike_cnt with the running count and reset the running count to 0, or to 1 if a rising edge occurs in the same cycle (that edge belongs to the new window).

Reset
REQ-027 SHALL, while reset_global=1, force: spike_out=0, spike_cnt=0, window_tick=0, pending=0, state IDLE, phase 0, running count 0, active and shadow period 0, active and shadow width 1.
REQ-028 SHALL reset the synchronizer and history flops to 1, so that sim_clk high at reset release produces no tick until sim_clk is seen low and then high.
REQ-029 SHALL, on reset asserted mid-pulse, drop spike_out to 0 asynchronously.

Verification
REQ-030 SHALL check: reset; load period=10, width=2; enable=1; one sim_clk edge -> spike_out high 2 cycles and low 8 cycles, repeating, with the first rise one cycle after window_tick.
REQ-031 SHALL check: active period=10, width=2, enable=1; sim_clk window of 1000 clk cycles, phase aligned -> spike_cnt=100 at the following tick.
REQ-032 SHALL check: period=4, width=9 -> 3 high / 1 low; width=0 -> 1 high / 3 low; period=1 -> treated as 2 (1 high / 1 low).
REQ-033 SHALL check: load period=20 mid-window while running period=10 -> pending=1 and period 10 continues until the tick; then phase restarts at period 20 and pending=0.
REQ-034 SHALL check: enable dropped on the 1st HIGH cycle of a width-5 pulse -> the pulse completes 5 cycles, then spike_out stays 0; period=0 -> spike_cnt=0 at the next tick.
REQ-035 SHALL check: reset_global asserted mid-pulse with sim_clk held high -> spike_out=0 and spike_cnt=0 immediately, and no window_tick after release until a new sim_clk rising edge.
